// File: rtl/button_gesture_ctrl.sv
// button_gesture_ctrl: classifies debounced button edges into short/double/long presses with auto-repeat
module button_gesture_ctrl #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 15_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       p_edge,
  input  logic       n_edge,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic       repeat_tick,
  output logic       long_release,
  output logic       busy,
  output logic [2:0] state
);
  localparam int MAX_A = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_C = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_C);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] pulse_q, pulse_d;
  logic pe, ne;

  assign pe = p_edge & ~n_edge;
  assign ne = n_edge & ~p_edge;
  assign {long_release, repeat_tick, long_press, double_press, short_press} = pulse_q;
  assign busy = state_q != IDLE;
  assign state = state_q;

  // next state, counter and pulse decisions; release/second-press win ties against timeouts
  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    case (state_q)
      IDLE:    state_d = pe ? PRESS1 : IDLE;
      PRESS1:  if (ne) state_d = WAIT2;
               else if (cnt_q == LONG_LAST) begin state_d = LONG; pulse_d[2] = 1'b1; end
      WAIT2:   if (pe) begin state_d = PRESS2; pulse_d[1] = 1'b1; end
               else if (cnt_q == DCLICK_LAST) begin state_d = IDLE; pulse_d[0] = 1'b1; end
      PRESS2:  state_d = ne ? IDLE : PRESS2;
      LONG:    if (ne) begin state_d = IDLE; pulse_d[4] = 1'b1; end
               else if (cnt_q == REPEAT_LAST) pulse_d[3] = 1'b1;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE || state_q == PRESS2 || pulse_d[3]) ? '0 : cnt_q + CW'(1);
    if (!en) begin
      state_d = IDLE;
      cnt_d = '0;
      pulse_d = '0;
    end
  end

  // state, counter and registered output pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
endmodule

// File: tb/tb_button_gesture_ctrl.sv
// tb_button_gesture_ctrl: scoreboard bench for button_gesture_ctrl
module tb_button_gesture_ctrl;
  localparam int LC = 20, DC = 10, RC = 5;
  localparam int SP = 0, DP = 1, LP = 2, RT = 3, LR = 4;

  logic clk = 1'b0, reset = 1'b1, en = 1'b1, p_edge = 1'b0, n_edge = 1'b0;
  logic short_press, double_press, long_press, repeat_tick, long_release, busy;
  logic [2:0] state;
  logic [4:0] pv;
  int cyc = 0, base = 0, vectors = 0, miscompares = 0;

  typedef struct {
    int c;
    int k;
  } exp_t;
  exp_t q[$];

  button_gesture_ctrl #(.LONG_CYCLES(LC), .DCLICK_CYCLES(DC), .REPEAT_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .en(en), .p_edge(p_edge), .n_edge(n_edge),
    .short_press(short_press), .double_press(double_press), .long_press(long_press),
    .repeat_tick(repeat_tick), .long_release(long_release), .busy(busy), .state(state)
  );

  assign pv = {long_release, repeat_tick, long_press, double_press, short_press};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int kind_of(logic [4:0] v);
    int k = -1;
    for (int i = 0; i < 5; i++) if (v[i]) k = i;
    return k;
  endfunction

  // monitor: every pulse the DUT presents is matched against the next expected event
  always @(negedge clk) begin
    if (pv != 5'd0) begin
      exp_t e;
      vectors++;
      if ($countones(pv) > 1) begin
        miscompares++;
        $display("FAIL multi_pulse: got pulses %b at cycle %0d, required one-hot", pv, cyc - base);
      end else if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got kind %0d at rel cycle %0d, required none", kind_of(pv), cyc - base);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.k != kind_of(pv)) begin
          miscompares++;
          $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d", kind_of(pv), cyc, e.k, e.c);
        end
      end
    end
  end

  task automatic at(int t);
    while (cyc < base + t) @(negedge clk);
  endtask

  task automatic start();
    @(negedge clk);
    base = cyc;
  endtask

  task automatic pe(int t);
    at(t);
    p_edge = 1'b1;
    @(negedge clk);
    p_edge = 1'b0;
  endtask

  task automatic ne(int t);
    at(t);
    n_edge = 1'b1;
    @(negedge clk);
    n_edge = 1'b0;
  endtask

  task automatic expect_ev(int t, int k);
    q.push_back('{base + t, k});
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic chk_st(int t, int st, int b);
    at(t);
    chk("state", int'(state), st);
    chk("busy", int'(busy), b);
  endtask

  initial begin
    #1;
    chk("reset_pulses", int'(pv), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // short press
    start(); expect_ev(16, SP);
    pe(0); ne(5); chk_st(15, 2, 1); chk_st(16, 0, 0); at(25);
    // double press
    start(); expect_ev(13, DP);
    pe(0); ne(5); pe(12); chk_st(14, 3, 1); ne(18); chk_st(19, 0, 0); at(30);
    // long press with repeats
    start(); expect_ev(21, LP); expect_ev(26, RT); expect_ev(31, RT); expect_ev(36, RT); expect_ev(39, LR);
    pe(0); chk_st(22, 4, 1); ne(38); chk_st(39, 0, 0); at(50);
    // release exactly on long threshold takes the short path
    start(); expect_ev(31, SP);
    pe(0); ne(20); chk_st(21, 2, 1); at(40);
    // second press on the double-window timeout cycle
    start(); expect_ev(16, DP);
    pe(0); ne(5); pe(15); ne(20); chk_st(21, 0, 0); at(35);
    // enable dropped during the double window
    start();
    pe(0); ne(5); at(8); en = 1'b0; chk_st(8, 2, 1);
    @(negedge clk); en = 1'b1; chk_st(9, 0, 0); at(30);
    // simultaneous edges in IDLE
    start();
    p_edge = 1'b1; n_edge = 1'b1;
    @(negedge clk); p_edge = 1'b0; n_edge = 1'b0;
    chk_st(1, 0, 0); chk_st(3, 0, 0); at(10);
    // async reset mid-LONG while a repeat pulse is visible
    start(); expect_ev(21, LP); expect_ev(26, RT);
    pe(0); at(26);
    #2 reset = 1'b1;
    #1;
    chk("async_pulses", int'(pv), 0);
    chk("async_state", int'(state), 0);
    chk("async_busy", int'(busy), 0);
    at(28); reset = 1'b0; at(32);
    // fresh gesture after reset
    start(); expect_ev(16, SP);
    pe(0); ne(5); at(25);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: got none, required kind %0d at cycle %0d", e.k, e.c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
